// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the data cache and its refill controller.
//   refill_state_t : refill FSM states (IDLE, REQ, WAIT, FILL)
//   BYTE_OFF_BITS / WORD_OFF_BITS / WORDS_PER_LINE : line geometry
//   get_index / get_tag : split a byte address into set index and tag, so the
//                         cache and the refill path always agree on the split
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int ADDR_BITS      = 32;
    localparam int BYTE_OFF_BITS  = 2;
    localparam int WORD_OFF_BITS  = 2;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_OFF_BITS  = BYTE_OFF_BITS + WORD_OFF_BITS;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } refill_state_t;

    // Set index sits directly above the byte and word offsets.
    function automatic logic [ADDR_BITS-1:0] get_index(input logic [ADDR_BITS-1:0] addr,
                                                       input int set_bits);
        return (addr >> LINE_OFF_BITS) & ((ADDR_BITS'(1) << set_bits) - ADDR_BITS'(1));
    endfunction

    // Tag is everything above the set index.
    function automatic logic [ADDR_BITS-1:0] get_tag(input logic [ADDR_BITS-1:0] addr,
                                                     input int set_bits);
        return addr >> (LINE_OFF_BITS + set_bits);
    endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// -----------------------------------------------------------------------------
// refill_line_buffer
// Holds the words of one cache line while they trickle in from main memory.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears all words)
//   wr_en           : write wr_data into the word selected by wr_sel
//   wr_sel[1:0]     : word slot to write
//   wr_data         : incoming memory word
//   word0..word3    : all buffered words in parallel
// -----------------------------------------------------------------------------
module refill_line_buffer
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [1:0]            wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] word0,
    output logic [DATA_WIDTH-1:0] word1,
    output logic [DATA_WIDTH-1:0] word2,
    output logic [DATA_WIDTH-1:0] word3
);

    logic [DATA_WIDTH-1:0] words [WORDS_PER_LINE];

    // One slot is written per returning memory beat; reset wipes the whole
    // line so an aborted refill can never leak stale words into a later fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_sel] <= wr_data;
        end
    end

    assign word0 = words[0];
    assign word1 = words[1];
    assign word2 = words[2];
    assign word3 = words[3];

endmodule

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
// Read-miss handler for a write-through, no-allocate data cache. On a read miss
// it stalls the pipeline, fetches the 4-word line one word at a time from main
// memory, then writes the whole line into the cache with a single fill strobe.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_we/req_addr    : load/store request from the pipeline
//   hit                          : cache tag match for req_addr
//   stall                        : freeze pipeline (combinational)
//   mem_ren/mem_addr             : one-cycle word read request to memory
//   mem_rdata/mem_rvalid         : memory read return
//   fill_we/fill_index/fill_tag  : one-cycle line write into the cache
//   fill_d0..fill_d3             : line words 0..3 for the fill
//   miss_count                   : saturating count of read misses
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int SET_BITS       = 3,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic [DATA_WIDTH-1:0]          req_addr,
    input  logic                           hit,
    output logic                           stall,
    output logic                           mem_ren,
    output logic [DATA_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    input  logic                           mem_rvalid,
    output logic                           fill_we,
    output logic [SET_BITS-1:0]            fill_index,
    output logic [DATA_WIDTH-4-SET_BITS-1:0] fill_tag,
    output logic [DATA_WIDTH-1:0]          fill_d0,
    output logic [DATA_WIDTH-1:0]          fill_d1,
    output logic [DATA_WIDTH-1:0]          fill_d2,
    output logic [DATA_WIDTH-1:0]          fill_d3,
    output logic [DATA_WIDTH-1:0]          miss_count
);

    import cache_pkg::*;

    localparam int TAG_BITS = DATA_WIDTH - LINE_OFF_BITS - SET_BITS;

    refill_state_t                         state;
    logic [WORD_OFF_BITS-1:0]              word_cnt;
    logic [DATA_WIDTH-LINE_OFF_BITS-1:0]   line_base;
    logic [DATA_WIDTH-1:0]                 line_addr;
    logic [DATA_WIDTH-1:0]                 line_w0, line_w1, line_w2, line_w3;
    logic                                  read_miss;
    logic                                  capture;
    logic                                  last_word;
    logic                                  unused_offset_bits;

    // The offset bits of the request never matter: a refill always fetches
    // the whole line starting at word 0.
    assign unused_offset_bits = ^req_addr[LINE_OFF_BITS-1:0];

    assign read_miss = req_valid & ~req_we & ~hit;
    assign capture   = (state == WAIT) & mem_rvalid;
    assign last_word = (word_cnt == WORD_OFF_BITS'(WORDS_PER_LINE - 1));
    assign line_addr = {line_base, {LINE_OFF_BITS{1'b0}}};

    // Stall has to rise in the very cycle the miss is seen, before the FSM
    // has left IDLE, so it is built from the live request as well as state.
    assign stall    = (state != IDLE) | read_miss;
    assign mem_addr = {line_base, word_cnt, {BYTE_OFF_BITS{1'b0}}};

    refill_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_sel  (word_cnt),
        .wr_data (mem_rdata),
        .word0   (line_w0),
        .word1   (line_w1),
        .word2   (line_w2),
        .word3   (line_w3)
    );

    // Refill FSM with registered strobes. mem_ren is raised on the edge that
    // enters REQ and fill_we on the edge that enters FILL, so each is high for
    // exactly that one state. The fill words are snapshotted on the edge that
    // delivers the last beat; that beat is still being written into the
    // buffer, so it is taken straight from mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_cnt   <= '0;
            line_base  <= '0;
            miss_count <= '0;
            mem_ren    <= 1'b0;
            fill_we    <= 1'b0;
            fill_index <= '0;
            fill_tag   <= '0;
            fill_d0    <= '0;
            fill_d1    <= '0;
            fill_d2    <= '0;
            fill_d3    <= '0;
        end else begin
            mem_ren <= 1'b0;
            fill_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_miss) begin
                        line_base <= req_addr[DATA_WIDTH-1:LINE_OFF_BITS];
                        word_cnt  <= '0;
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 1'b1;
                        end
                        mem_ren <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (last_word) begin
                            fill_we    <= 1'b1;
                            fill_index <= SET_BITS'(get_index(ADDR_BITS'(line_addr), SET_BITS));
                            fill_tag   <= TAG_BITS'(get_tag(ADDR_BITS'(line_addr), SET_BITS));
                            fill_d0    <= (word_cnt == 2'd0) ? mem_rdata : line_w0;
                            fill_d1    <= (word_cnt == 2'd1) ? mem_rdata : line_w1;
                            fill_d2    <= (word_cnt == 2'd2) ? mem_rdata : line_w2;
                            fill_d3    <= (word_cnt == 2'd3) ? mem_rdata : line_w3;
                            state      <= FILL;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                            mem_ren  <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                FILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
// Directed bench for the read-miss refill controller. Each scenario task drives
// its own stimulus and checks results against hand-computed values. A small
// behavioural memory answers mem_ren after a configurable latency.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

    localparam int DW    = 32;
    localparam int SB    = 3;
    localparam int TAG_W = DW - 4 - SB;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_we;
    logic [DW-1:0]    req_addr;
    logic             hit;
    logic             stall;
    logic             mem_ren;
    logic [DW-1:0]    mem_addr;
    logic [DW-1:0]    mem_rdata;
    logic             mem_rvalid;
    logic             fill_we;
    logic [SB-1:0]    fill_index;
    logic [TAG_W-1:0] fill_tag;
    logic [DW-1:0]    fill_d0, fill_d1, fill_d2, fill_d3;
    logic [DW-1:0]    miss_count;

    int tests_run;
    int tests_failed;

    // Observations from the most recent run_read_miss
    logic [DW-1:0]    obs_addr [$];
    int               obs_stall_cycles;
    int               obs_fill_count;
    int               obs_fill_cycle;
    logic [SB-1:0]    obs_index;
    logic [TAG_W-1:0] obs_tag;
    logic [DW-1:0]    obs_d [4];
    bit               obs_done;

    cache_refill_ctrl #(
        .DATA_WIDTH     (DW),
        .SET_BITS       (SB),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .hit        (hit),
        .stall      (stall),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .fill_we    (fill_we),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_d0    (fill_d0),
        .fill_d1    (fill_d1),
        .fill_d2    (fill_d2),
        .fill_d3    (fill_d3),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Hold a read miss on the request bus and play memory with the given
    // latency. Memory word k returns data_base + k. The cache reports a hit
    // once the fill has been seen. Records observations only.
    task automatic run_read_miss(input logic [DW-1:0] addr, input int lat,
                                 input logic [DW-1:0] data_base, input bit release_sat);
        int cd;
        int pend_word;
        bit filled;
        cd = -1;
        pend_word = 0;
        filled = 0;
        obs_addr.delete();
        obs_stall_cycles = 0;
        obs_fill_count = 0;
        obs_fill_cycle = -1;
        obs_done = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        for (int k = 0; k < 100; k++) begin
            if (release_sat && k == 1) begin
                release dut.miss_count;
            end
            if (cd > 0) cd--;
            if (cd == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data_base + 32'(pend_word);
                cd = -1;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hDEAD_BEEF;
            end
            hit = filled;
            #1;
            if (stall) obs_stall_cycles++;
            if (mem_ren) begin
                obs_addr.push_back(mem_addr);
                pend_word = int'(mem_addr[3:2]);
                cd = lat;
            end
            if (fill_we) begin
                obs_fill_count++;
                obs_fill_cycle = k;
                obs_index = fill_index;
                obs_tag   = fill_tag;
                obs_d[0]  = fill_d0;
                obs_d[1]  = fill_d1;
                obs_d[2]  = fill_d2;
                obs_d[3]  = fill_d3;
                filled = 1;
            end
            if (filled && !stall && !fill_we) begin
                obs_done = 1;
                break;
            end
            @(negedge clk);
        end
        req_valid  = 1'b0;
        hit        = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        tests_run++;
        if (mem_ren !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_ren: got %b expected 0", mem_ren); end
        tests_run++;
        if (fill_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fill_we: got %b expected 0", fill_we); end
        tests_run++;
        if ({fill_d0, fill_d1, fill_d2, fill_d3} !== 128'h0) begin
            tests_failed++; $display("[TB] FAIL reset_fill_d: got %h %h %h %h expected all 0", fill_d0, fill_d1, fill_d2, fill_d3);
        end
        tests_run++;
        if (miss_count !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_miss_count: got %0h expected 0", miss_count); end
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        logic [DW-1:0] exp_addr;
        run_read_miss(32'h0000_0124, 1, 32'h0000_00A0, 1'b0);
        tests_run++;
        if (!obs_done) begin tests_failed++; $display("[TB] FAIL miss_timeout: refill did not finish within 100 cycles"); end
        tests_run++;
        if (obs_addr.size() != 4) begin tests_failed++; $display("[TB] FAIL miss_ren_count: got %0d expected 4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            exp_addr = 32'h0000_0120 + 32'(4 * i);
            tests_run++;
            if (obs_addr[i] !== exp_addr) begin tests_failed++; $display("[TB] FAIL miss_addr%0d: got %h expected %h", i, obs_addr[i], exp_addr); end
        end
        tests_run++;
        if (obs_fill_count != 1) begin tests_failed++; $display("[TB] FAIL miss_fill_count: got %0d expected 1", obs_fill_count); end
        tests_run++;
        if (obs_fill_cycle != 9) begin tests_failed++; $display("[TB] FAIL miss_fill_cycle: got %0d expected 9", obs_fill_cycle); end
        // 0x124: index = bits[6:4] = 2, tag = bits[31:7] = 2
        tests_run++;
        if (obs_index !== 3'd2) begin tests_failed++; $display("[TB] FAIL miss_fill_index: got %0d expected 2", obs_index); end
        tests_run++;
        if (obs_tag !== 25'h2) begin tests_failed++; $display("[TB] FAIL miss_fill_tag: got %h expected 2", obs_tag); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (obs_d[i] !== 32'h0000_00A0 + 32'(i)) begin
                tests_failed++; $display("[TB] FAIL miss_fill_d%0d: got %h expected %h", i, obs_d[i], 32'h0000_00A0 + 32'(i));
            end
        end
        tests_run++;
        if (obs_stall_cycles != 10) begin tests_failed++; $display("[TB] FAIL miss_stall_cycles: got %0d expected 10", obs_stall_cycles); end
        tests_run++;
        if (miss_count !== 32'd1) begin tests_failed++; $display("[TB] FAIL miss_count_after_miss: got %0d expected 1", miss_count); end
    endtask

    task automatic test_read_hit();
        req_valid = 1'b1;
        req_we    = 1'b0;
        hit       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = 32'h0000_0120 + 32'(k * 36);
            #1;
            tests_run++;
            if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_stall%0d: got %b expected 0", k, stall); end
            tests_run++;
            if (mem_ren !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_mem_ren%0d: got %b expected 0", k, mem_ren); end
            @(negedge clk);
        end
        req_valid = 1'b0;
        hit       = 1'b0;
        #1;
        tests_run++;
        if (mem_ren !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_mem_ren_after: got %b expected 0", mem_ren); end
        tests_run++;
        if (miss_count !== 32'd1) begin tests_failed++; $display("[TB] FAIL hit_miss_count: got %0d expected 1", miss_count); end
        @(negedge clk);
    endtask

    task automatic test_store_miss();
        int ren_seen;
        int fill_seen;
        ren_seen = 0;
        fill_seen = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0040;
        hit       = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) req_valid = 1'b0;
            #1;
            if (k < 4) begin
                tests_run++;
                if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_stall%0d: got %b expected 0", k, stall); end
            end
            if (mem_ren) ren_seen++;
            if (fill_we) fill_seen++;
            @(negedge clk);
        end
        req_we = 1'b0;
        tests_run++;
        if (ren_seen != 0) begin tests_failed++; $display("[TB] FAIL store_mem_ren: got %0d pulses expected 0", ren_seen); end
        tests_run++;
        if (fill_seen != 0) begin tests_failed++; $display("[TB] FAIL store_fill_we: got %0d pulses expected 0", fill_seen); end
        tests_run++;
        if (miss_count !== 32'd1) begin tests_failed++; $display("[TB] FAIL store_miss_count: got %0d expected 1", miss_count); end
    endtask

    task automatic test_slow_memory();
        logic [DW-1:0] exp_addr;
        run_read_miss(32'h0000_3A58, 3, 32'h5500_0010, 1'b0);
        tests_run++;
        if (!obs_done) begin tests_failed++; $display("[TB] FAIL slow_timeout: refill did not finish within 100 cycles"); end
        tests_run++;
        if (obs_addr.size() != 4) begin tests_failed++; $display("[TB] FAIL slow_ren_count: got %0d expected 4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            exp_addr = 32'h0000_3A50 + 32'(4 * i);
            tests_run++;
            if (obs_addr[i] !== exp_addr) begin tests_failed++; $display("[TB] FAIL slow_addr%0d: got %h expected %h", i, obs_addr[i], exp_addr); end
        end
        tests_run++;
        if (obs_stall_cycles != 18) begin tests_failed++; $display("[TB] FAIL slow_stall_cycles: got %0d expected 18", obs_stall_cycles); end
        tests_run++;
        if (obs_fill_cycle != 17) begin tests_failed++; $display("[TB] FAIL slow_fill_cycle: got %0d expected 17", obs_fill_cycle); end
        // 0x3A58: index = bits[6:4] = 5, tag = bits[31:7] = 0x74
        tests_run++;
        if (obs_index !== 3'd5) begin tests_failed++; $display("[TB] FAIL slow_fill_index: got %0d expected 5", obs_index); end
        tests_run++;
        if (obs_tag !== 25'h74) begin tests_failed++; $display("[TB] FAIL slow_fill_tag: got %h expected 74", obs_tag); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (obs_d[i] !== 32'h5500_0010 + 32'(i)) begin
                tests_failed++; $display("[TB] FAIL slow_fill_d%0d: got %h expected %h", i, obs_d[i], 32'h5500_0010 + 32'(i));
            end
        end
        tests_run++;
        if (miss_count !== 32'd2) begin tests_failed++; $display("[TB] FAIL slow_miss_count: got %0d expected 2", miss_count); end
    endtask

    task automatic test_reset_abort();
        int ren_seen;
        int cd;
        int fill_seen;
        int ren_after;
        ren_seen = 0;
        cd = -1;
        fill_seen = 0;
        ren_after = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0200;
        hit       = 1'b0;
        // Run until the request for word 2 goes out
        for (int k = 0; k < 40; k++) begin
            if (cd > 0) cd--;
            if (cd == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h0000_0077;
                cd = -1;
            end else begin
                mem_rvalid = 1'b0;
            end
            #1;
            if (mem_ren) begin
                ren_seen++;
                cd = 1;
            end
            if (ren_seen == 3) break;
            @(negedge clk);
        end
        tests_run++;
        if (ren_seen != 3) begin tests_failed++; $display("[TB] FAIL abort_reach_word2: got %0d requests expected 3", ren_seen); end
        // Now in WAIT for word 2: reset instead of delivering data
        @(negedge clk);
        mem_rvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_stall: got %b expected 0", stall); end
        tests_run++;
        if ({fill_d0, fill_d1, fill_d2, fill_d3} !== 128'h0) begin
            tests_failed++; $display("[TB] FAIL abort_fill_d: got %h %h %h %h expected all 0", fill_d0, fill_d1, fill_d2, fill_d3);
        end
        tests_run++;
        if (miss_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL abort_miss_count: got %0d expected 0", miss_count); end
        tests_run++;
        if (mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL abort_mem_addr: got %h expected 0", mem_addr); end
        // Late data from the aborted refill must be ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0099;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (fill_we) fill_seen++;
            if (mem_ren) ren_after++;
            tests_run++;
            if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL stray_stall%0d: got %b expected 0", k, stall); end
            @(negedge clk);
        end
        tests_run++;
        if (fill_seen != 0) begin tests_failed++; $display("[TB] FAIL stray_fill_we: got %0d pulses expected 0", fill_seen); end
        tests_run++;
        if (ren_after != 0) begin tests_failed++; $display("[TB] FAIL stray_mem_ren: got %0d pulses expected 0", ren_after); end
        tests_run++;
        if (fill_d0 !== 32'h0) begin tests_failed++; $display("[TB] FAIL stray_fill_d0: got %h expected 0", fill_d0); end
    endtask

    task automatic test_saturate();
        force dut.miss_count = 32'hFFFF_FFFF;
        run_read_miss(32'h0000_0F70, 1, 32'hC0DE_0000, 1'b1);
        tests_run++;
        if (!obs_done) begin tests_failed++; $display("[TB] FAIL sat_timeout: refill did not finish within 100 cycles"); end
        tests_run++;
        if (miss_count !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL sat_miss_count: got %h expected ffffffff", miss_count); end
        tests_run++;
        if (obs_fill_count != 1) begin tests_failed++; $display("[TB] FAIL sat_fill_count: got %0d expected 1", obs_fill_count); end
        // 0xF70: index = bits[6:4] = 7, tag = bits[31:7] = 0x1E
        tests_run++;
        if (obs_index !== 3'd7) begin tests_failed++; $display("[TB] FAIL sat_fill_index: got %0d expected 7", obs_index); end
        tests_run++;
        if (obs_tag !== 25'h1E) begin tests_failed++; $display("[TB] FAIL sat_fill_tag: got %h expected 1e", obs_tag); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (obs_d[i] !== 32'hC0DE_0000 + 32'(i)) begin
                tests_failed++; $display("[TB] FAIL sat_fill_d%0d: got %h expected %h", i, obs_d[i], 32'hC0DE_0000 + 32'(i));
            end
        end
        tests_run++;
        if (obs_stall_cycles != 10) begin tests_failed++; $display("[TB] FAIL sat_stall_cycles: got %0d expected 10", obs_stall_cycles); end
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        hit          = 1'b0;
        mem_rdata    = '0;
        mem_rvalid   = 1'b0;
        tests_run    = 0;
        tests_failed = 0;
        @(negedge clk);
        test_reset();
        test_read_miss();
        test_read_hit();
        test_store_miss();
        test_slow_memory();
        test_reset_abort();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
